// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-file debug dump reader.
// Holds the dump FSM state encoding and the default register-file geometry
// used by the register file, the debug mux and the reader itself.
package reg_dump_pkg;

  // Default register-file geometry (32 x 32-bit, 5-bit index).
  localparam int DEF_NREGS  = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  // Dump FSM state width and encoding.
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    CKSUM = 3'd3,
    DONE  = 3'd4
  } state_t;

  // True when idx is the highest register index of an nregs-entry file.
  function automatic logic is_last_idx(input int unsigned idx, input int unsigned nregs);
    return (idx == nregs - 1);
  endfunction

endpackage

// File: rtl/reg_dump_reader.sv
// Register-file debug dump reader.
// On a start pulse, walks register indices FIRST_REG..NREGS-1 through one
// combinational read port and streams each word on a valid/ready interface.
// Each word takes a FETCH cycle (address out, data captured) and at least one
// SEND cycle (beat presented until accepted), so throughput is at most one
// beat every two cycles.
// Optional feature: define REG_DUMP_CHECKSUM_EN to append one extra beat
// carrying the XOR of all dumped words (out_idx = 0, out_last = 1).
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int NREGS     = DEF_NREGS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FIRST_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [ADDR_W-1:0] oidx_reg, oidx_next;
  logic              last_reg, last_next;
  logic              valid_reg, valid_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              hs;
  logic              at_last;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_reg, acc_next;
`endif

  assign hs      = valid_reg && out_ready;
  assign at_last = is_last_idx(32'(idx_reg), NREGS);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, read address and next datapath values.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    oidx_next  = oidx_reg;
    last_next  = last_reg;
    valid_next = valid_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    rf_addr    = '0;
`ifdef REG_DUMP_CHECKSUM_EN
    acc_next   = acc_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          idx_next   = FIRST_IDX;
          busy_next  = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          acc_next   = '0;
`endif
        end
      end
      FETCH: begin
        // The read port is combinational: present the index and capture the
        // word on the same edge, so the beat reflects the file in this cycle.
        rf_addr    = idx_reg;
        data_next  = rf_data;
        oidx_next  = idx_reg;
`ifdef REG_DUMP_CHECKSUM_EN
        last_next  = 1'b0;
`else
        last_next  = at_last;
`endif
        valid_next = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (hs) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          acc_next   = acc_reg ^ data_reg;
`endif
          if (at_last) begin
`ifdef REG_DUMP_CHECKSUM_EN
            state_next = CKSUM;
`else
            state_next = DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
`endif
          end else begin
            // idx stops at the last register; it never wraps.
            idx_next   = idx_reg + ADDR_W'(1);
            state_next = FETCH;
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CKSUM: begin
        // First cycle loads the checksum beat; it then waits for acceptance.
        if (!valid_reg) begin
          data_next  = acc_reg;
          oidx_next  = '0;
          last_next  = 1'b1;
          valid_next = 1'b1;
        end else if (hs) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        last_next  = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Datapath and status registers; reset aborts any dump without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg   <= '0;
      data_reg  <= '0;
      oidx_reg  <= '0;
      last_reg  <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      oidx_reg  <= oidx_next;
      last_reg  <= last_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  // XOR accumulator over every accepted data beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end
`endif

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_idx   = oidx_reg;
  assign out_last  = last_reg;

endmodule
